button_gesture_classifier: RTL and testbench
============================================

# button_gesture_classifier

Downstream consumer of the switch debouncer's clean level output. Classifies each press of one debounced button into a short press, long press or double click, each reported as a one-cycle pulse. Optionally emits auto-repeat pulses while a long press is held. Sits between the debouncer and UI/control logic, so that logic never handles raw timing.

## Interface
Parameters:
- LONG_COUNT, default 50000000: hold cycles that qualify a long press (1 s at 50 MHz); ≥2.
- GAP_COUNT, default 15000000: maximum release-to-second-press gap, in cycles, for a double click; ≥2.
- REPEAT_COUNT, default 10000000: auto-repeat period in cycles; ≥2.
- CNT_WIDTH, default $clog2 of the largest of the three counts, +1: counter width.

Ports (one clock; reset is synchronous and active-low):
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset.
- btn_level, input, 1: debounced button level, 1 = pressed, synchronous to clk.
- short_press, output, 1: one-cycle pulse marking a short press.
- long_press, output, 1: one-cycle pulse when the hold reaches LONG_COUNT.
- double_click, output, 1: one-cycle pulse on release of the second press.
- repeat_pulse, output, 1: one-cycle auto-repeat pulse; tied 0 when BTN_REPEAT_EN is undefined.
- busy, output, 1: high whenever the state is not IDLE.

## Operation
- prev_level is a register holding the previous btn_level.
- rise = btn_level & !prev_level.
- fall = !btn_level & prev_level.
- A single counter is cleared on every state entry and increments each cycle the state is held.
- States:
  - IDLE: on rise, go to PRESS1.
  - PRESS1: on fall, go to GAP. On timeout (counter reaches LONG_COUNT-1 with no fall), pulse long_press and go to HELD.
  - GAP: on rise, go to PRESS2. On timeout (GAP_COUNT-1 with no rise), pulse short_press and go to IDLE.
  - PRESS2: on fall, pulse double_click and go to IDLE. There is no timeout; the hold duration of the second press is ignored.
  - HELD: on fall, go to IDLE with no pulse. With BTN_REPEAT_EN, pulse repeat_pulse each time the counter reaches REPEAT_COUNT-1, then clear the counter.
  - Unused state encodings go to IDLE.
- An edge event takes priority over a timeout in the same cycle. A release sampled on the long-timeout cycle is therefore a short-press candidate, not a long press.
- At most one of short_press, long_press and double_click is high in any cycle.
- The counter saturates and never wraps; it cannot exceed a count by design, and saturation is a safety net only.

## Timing
- All outputs are registered. Reset value is 0 for every output, for state (IDLE) and for the counter.
- prev_level resets to 1. A button held through reset is therefore ignored until it is released and pressed again.
- Reset asserted mid-gesture aborts the gesture with no pulse; outputs are 0 on the cycle after the reset edge.
- A state entered at edge k times out at edge k+N, where N is the relevant count. The pulse is visible from edge k+N for exactly one cycle.
- long_press asserts LONG_COUNT cycles after the edge where the rise was sampled.
- short_press asserts GAP_COUNT cycles after the edge where the fall was sampled. The total latency of a short press is therefore press duration + GAP_COUNT.
- double_click asserts at the edge where the second fall is sampled.
- The first repeat_pulse asserts REPEAT_COUNT cycles after long_press, then every REPEAT_COUNT cycles.
- busy tracks the state register with no added delay.

## Configuration
- BTN_REPEAT_EN defined: the auto-repeat counter behaviour in HELD is compiled in.
- BTN_REPEAT_EN undefined: repeat_pulse is constant 0, HELD only waits for release, and REPEAT_COUNT is unused.
- All other behaviour is identical in both builds.

## Test plan
Parameters for every scenario: LONG_COUNT=8, GAP_COUNT=5, REPEAT_COUNT=4, BTN_REPEAT_EN defined unless stated.
- Short press: btn_level 1 for 3 cycles, then 0 → short_press high for exactly one cycle, 5 cycles after the fall edge. No other pulses.
- Double click: 1 for 2 cycles, 0 for 3 cycles, 1 for 10 cycles, then 0 → double_click pulses on the second fall. No short_press and no long_press.
- Long press with repeat: btn_level held 1 for 25 cycles, then 0 → long_press at cycle 8, then repeat_pulse at cycles 12, 16, 20 and 24. Nothing after the release. A second build without the macro → repeat_pulse stays 0.
- Release on the timeout cycle: fall sampled exactly 8 cycles after the rise → no long_press; short_press 5 cycles after the fall.
- Held through reset: btn_level=1 during and after rst_n deassert → no pulse and busy=0. After a 0-then-1 sequence, normal classification resumes.
- Reset mid-gesture: rst_n low for one cycle while in GAP → all outputs and busy are 0 the next cycle, and no short_press ever appears for the aborted gesture.

Source files
------------

// File: rtl/button_gesture_classifier_if.sv
// ============================================================================
// Module      : button_gesture_classifier_if
// Description : Signal bundle between a debounced button source and the
//               gesture classifier. The master drives the button level and
//               observes the gesture pulses; the slave is the classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_gesture_classifier_if;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_pulse;
  logic busy;

  modport master (
    output btn_level,
    input  short_press,
    input  long_press,
    input  double_click,
    input  repeat_pulse,
    input  busy
  );

  modport slave (
    input  btn_level,
    output short_press,
    output long_press,
    output double_click,
    output repeat_pulse,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/button_gesture_classifier.sv
// ============================================================================
// Module      : button_gesture_classifier
// Description : Classifies presses of one debounced button into short press,
//               long press or double click, each reported as a one-cycle
//               registered pulse. Optional auto-repeat while a long press is
//               held, compiled in when the macro BTN_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_gesture_classifier #(
  parameter int LONG_COUNT   = 50000000,
  parameter int GAP_COUNT    = 15000000,
  parameter int REPEAT_COUNT = 10000000,
  parameter int CNT_WIDTH    = $clog2(
      (LONG_COUNT > GAP_COUNT)
        ? ((LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT)
        : ((GAP_COUNT  > REPEAT_COUNT) ? GAP_COUNT  : REPEAT_COUNT)) + 1
) (
  input wire                         clk,
  input wire                         rst_n,
  button_gesture_classifier_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_GAP    = 3'd2,
    S_PRESS2 = 3'd3,
    S_HELD   = 3'd4
  } state_t;

  // Counter values on which the respective timeouts fire.
  localparam logic [CNT_WIDTH-1:0] c_long_last = CNT_WIDTH'(LONG_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] c_gap_last  = CNT_WIDTH'(GAP_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] c_rep_last  = CNT_WIDTH'(REPEAT_COUNT - 1);
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_cnt_clr;
  logic                 r_prev;
  logic                 w_rise;
  logic                 w_fall;
  logic                 r_short;
  logic                 r_long;
  logic                 r_dbl;
  logic                 w_short_nxt;
  logic                 w_long_nxt;
  logic                 w_dbl_nxt;
`ifdef BTN_REPEAT_EN
  logic                 r_rep;
  logic                 w_rep_nxt;
`endif

  // prev resets high so a button held through reset never counts as a press.
  assign w_rise = bus.btn_level & ~r_prev;
  assign w_fall = ~bus.btn_level & r_prev;

  // Next-state, pulse and counter decode; edges win over timeouts.
  always_comb begin
    w_state_nxt = r_state;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    w_dbl_nxt   = 1'b0;
    w_cnt_clr   = 1'b0;
`ifdef BTN_REPEAT_EN
    w_rep_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (w_fall) begin
          w_state_nxt = S_GAP;
        end else if (r_cnt == c_long_last) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = S_HELD;
        end
      end
      S_GAP: begin
        if (w_rise) begin
          w_state_nxt = S_PRESS2;
        end else if (r_cnt == c_gap_last) begin
          w_short_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (w_fall) begin
          w_dbl_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HELD: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (r_cnt == c_rep_last) begin
          w_rep_nxt = 1'b1;
          w_cnt_clr = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Every state entry restarts the counter; otherwise count up, saturating.
    if (w_state_nxt != r_state) w_cnt_clr = 1'b1;
    if (w_cnt_clr)                w_cnt_nxt = '0;
    else if (r_cnt == c_cnt_max)  w_cnt_nxt = r_cnt;
    else                          w_cnt_nxt = r_cnt + c_cnt_one;
  end

  // State, counter, edge history and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b1;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_dbl   <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_rep   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= bus.btn_level;
      r_short <= w_short_nxt;
      r_long  <= w_long_nxt;
      r_dbl   <= w_dbl_nxt;
`ifdef BTN_REPEAT_EN
      r_rep   <= w_rep_nxt;
`endif
    end
  end

  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.double_click = r_dbl;
  assign bus.busy         = (r_state != S_IDLE);
`ifdef BTN_REPEAT_EN
  assign bus.repeat_pulse = r_rep;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_gesture_classifier.sv
// ============================================================================
// Module      : tb_button_gesture_classifier
// Description : Self-checking bench for button_gesture_classifier. Button
//               waveforms are built as run lists (directed and random); the
//               expected pulses are derived per gesture from press/release
//               times. Repeat expectations follow the BTN_REPEAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_gesture_classifier;

  localparam int LONG_COUNT   = 8;
  localparam int GAP_COUNT    = 5;
  localparam int REPEAT_COUNT = 4;
  localparam int MAXN         = 512;

  // Bit positions in the packed output word.
  localparam int B_SHORT = 0;
  localparam int B_LONG  = 1;
  localparam int B_DBL   = 2;
  localparam int B_REP   = 3;
  localparam int B_BUSY  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  button_gesture_classifier_if bif();

  button_gesture_classifier #(
    .LONG_COUNT   (LONG_COUNT),
    .GAP_COUNT    (GAP_COUNT),
    .REPEAT_COUNT (REPEAT_COUNT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic       lv   [0:MAXN-1];
  logic [4:0] expv [0:MAXN-1];
  int         n_lv   = 0;
  int         seg_id = 0;

  task automatic check_eq(input string tag, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (busy,rep,dbl,long,short)", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_out();
    return {bif.busy, bif.repeat_pulse, bif.double_click, bif.long_press, bif.short_press};
  endfunction

  task automatic push(input logic l, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (n_lv < MAXN) begin
        lv[n_lv] = l;
        n_lv++;
      end
    end
  endtask

  // First index >= s where the level rises; the level before index 0 is 1.
  function automatic int find_rise(input int s, input int n);
    for (int i = s; i < n; i++) begin
      if (lv[i] && !((i == 0) ? 1'b1 : lv[i-1])) return i;
    end
    return n;
  endfunction

  function automatic int find_level(input int s, input int n, input logic l);
    for (int i = s; i < n; i++) begin
      if (lv[i] == l) return i;
    end
    return n;
  endfunction

  task automatic mark(input int i, input int n, input int b);
    if (i >= 0 && i < n) expv[i][b] = 1'b1;
  endtask

  task automatic mark_busy(input int a, input int b, input int n);
    for (int i = a; i < b && i < n; i++) expv[i][B_BUSY] = 1'b1;
  endtask

  // Gesture-level reference: walk press/release times and place pulses.
  task automatic build_model(input int n);
    int e;
    int t;
    int f;
    int r;
    int f2;
    for (int i = 0; i < n; i++) expv[i] = '0;
    e = 0;
    while (e < n) begin
      t = find_rise(e, n);
      if (t >= n) break;
      f = find_level(t + 1, n, 1'b0);
      if (f - t > LONG_COUNT) begin
        mark(t + LONG_COUNT, n, B_LONG);
`ifdef BTN_REPEAT_EN
        for (int k = t + LONG_COUNT + REPEAT_COUNT; k < f; k += REPEAT_COUNT)
          mark(k, n, B_REP);
`endif
        mark_busy(t, f, n);
        e = f;
      end else begin
        r = find_level(f + 1, n, 1'b1);
        if (r <= f + GAP_COUNT) begin
          f2 = find_level(r + 1, n, 1'b0);
          mark(f2, n, B_DBL);
          mark_busy(t, f2, n);
          e = f2;
        end else begin
          mark(f + GAP_COUNT, n, B_SHORT);
          mark_busy(t, f + GAP_COUNT, n);
          e = f + GAP_COUNT + 1;
        end
      end
    end
  endtask

  // Drive the current waveform one edge at a time and compare after each edge.
  task automatic run_seg();
    build_model(n_lv);
    for (int e = 0; e < n_lv; e++) begin
      bif.btn_level = lv[e];
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("seg%0d e%0d", seg_id, e), dut_out(), expv[e]);
    end
    n_lv = 0;
    seg_id++;
  endtask

  task automatic do_reset(input logic lvl);
    bif.btn_level = lvl;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq($sformatf("reset%0d", seg_id), dut_out(), 5'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic lvl;
    int   cnt;
    bif.btn_level = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Short press
    push(0, 2); push(1, 3); push(0, 20); run_seg(); do_reset(1'b0);
    // Double click
    push(0, 2); push(1, 2); push(0, 3); push(1, 10); push(0, 20); run_seg(); do_reset(1'b0);
    // Long press (with repeats when compiled in)
    push(0, 2); push(1, 25); push(0, 20); run_seg(); do_reset(1'b0);
    // Release on the long-timeout cycle
    push(0, 2); push(1, 8); push(0, 20); run_seg(); do_reset(1'b0);
    // Release one cycle after the long timeout
    push(0, 2); push(1, 9); push(0, 20); run_seg(); do_reset(1'b0);
    // Second press exactly on the gap timeout, then one cycle too late
    push(0, 2); push(1, 2); push(0, 5); push(1, 3); push(0, 20); run_seg(); do_reset(1'b0);
    push(0, 2); push(1, 2); push(0, 6); push(1, 3); push(0, 20); run_seg();

    // Held through reset, then a fresh press
    do_reset(1'b1);
    push(1, 10); push(0, 3); push(1, 3); push(0, 20); run_seg();

    // Reset while in the gap: the aborted gesture must never report
    do_reset(1'b0);
    push(0, 2); push(1, 3); push(0, 2); run_seg();
    do_reset(1'b0);
    push(0, 20); run_seg();

    // Random run-length waveforms
    for (int s = 0; s < 12; s++) begin
      do_reset(1'($urandom_range(0, 1)));
      lvl = 1'($urandom_range(0, 1));
      while (n_lv < 250) begin
        if ($urandom_range(0, 3) == 0) cnt = int'($urandom_range(9, 30));
        else                           cnt = int'($urandom_range(1, 12));
        push(lvl, cnt);
        lvl = ~lvl;
      end
      push(0, 20);
      run_seg();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
